// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and types for the BCD up/down counter.
//   DIGIT_W / DIGIT_MAX : BCD digit width and largest legal digit value
//   rpt_state_t         : per-direction auto-repeat FSM encoding
//   max_int()           : elaboration helper for sizing the hold counter
package bcd_updown_counter_pkg;

  localparam int                   DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0]   DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter datapath (purely combinational).
//   inc, dec   : step requests rippling in from the next lower digit
//   clear      : forces next_value to 0
//   value      : current registered digit
//   next_value : digit after the step
//   carry      : increment rolled 9->0, feed to next digit's inc
//   borrow     : decrement rolled 0->9, feed to next digit's dec
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic               inc,
  input  logic               dec,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] next_value,
  output logic               carry,
  output logic               borrow
);

  always_comb begin
    next_value = value;
    carry      = 1'b0;
    borrow     = 1'b0;
    if (clear) begin
      next_value = '0;
    end else if (inc) begin
      // >= so a corrupted digit (>9) recovers to 0 instead of counting on
      if (value >= DIGIT_MAX) begin
        next_value = '0;
        carry      = 1'b1;
      end else begin
        next_value = value + 1'b1;
      end
    end else if (dec) begin
      if (value == '0) begin
        next_value = DIGIT_MAX;
        borrow     = 1'b1;
      end else begin
        next_value = value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter driven by debounced buttons, with
// edge-triggered steps and press-and-hold auto-repeat per direction.
//   i_Clk, i_Reset     : clock, async active-high reset
//   i_Up, i_Down       : debounced button levels
//   i_Clear            : synchronous clear, beats any step
//   o_Digits           : BCD value, digit 0 in bits [3:0]
//   o_Wrap             : one-cycle pulse when the value wraps around
//   o_At_Max, o_At_Min : all-9 / all-0 decodes of o_Digits
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter bit WRAP_EN       = 1'b1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_Up,
  input  logic                          i_Down,
  input  logic                          i_Clear,
  output logic [DIGIT_W*NUM_DIGITS-1:0] o_Digits,
  output logic                          o_Wrap,
  output logic                          o_At_Max,
  output logic                          o_At_Min
);

  localparam int               CNT_W    = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // index 0 = up, 1 = down
  logic [1:0] lvl;
  logic [1:0] step;
  assign lvl = {i_Down, i_Up};

  // ---------------- per-direction edge detect + auto-repeat ----------------
  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic             lvl_q;
    logic             edge_det;
    logic             stp;
    rpt_state_t       st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    assign edge_det = lvl[d] & ~lvl_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        lvl_q <= 1'b0;
        st    <= ST_IDLE;
        cnt   <= '0;
      end else begin
        lvl_q <= lvl[d];
        st    <= st_nx;
        cnt   <= cnt_nx;
      end
    end

    // cnt counts cycles the button has been held; the edge cycle is count 0,
    // so the first repeat fires with cnt == REPEAT_DELAY and subsequent ones
    // every REPEAT_PERIOD cycles (cnt restarts at 1 after each repeat step).
    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      stp    = 1'b0;
      if (i_Clear || !lvl[d]) begin
        st_nx  = ST_IDLE;
        cnt_nx = '0;
      end else begin
        case (st)
          ST_IDLE: begin
            // a level still high after clear stays parked here until released
            if (edge_det) begin
              stp    = 1'b1;
              st_nx  = ST_HOLD;
              cnt_nx = ONE_C;
            end
          end
          ST_HOLD: begin
            if (REPEAT_DELAY == 0) begin
              cnt_nx = cnt;
            end else if (cnt >= DELAY_C) begin
              stp    = 1'b1;
              st_nx  = ST_REPEAT;
              cnt_nx = ONE_C;
            end else begin
              cnt_nx = cnt + ONE_C;
            end
          end
          ST_REPEAT: begin
            if (cnt >= PERIOD_C) begin
              stp    = 1'b1;
              cnt_nx = ONE_C;
            end else begin
              cnt_nx = cnt + ONE_C;
            end
          end
          default: begin
            st_nx  = ST_IDLE;
            cnt_nx = '0;
          end
        endcase
      end
    end

    assign step[d] = stp;
  end

  // ---------------- BCD datapath ----------------
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_nx;
  logic [NUM_DIGITS:0]                inc_c, dec_c;
  logic                               ovf;

  // opposing steps in the same cycle cancel out
  assign inc_c[0] = step[0] & ~step[1];
  assign dec_c[0] = step[1] & ~step[0];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    bcd_digit u_digit (
      .inc        (inc_c[k]),
      .dec        (dec_c[k]),
      .clear      (i_Clear),
      .value      (digits_q[k]),
      .next_value (digits_nx[k]),
      .carry      (inc_c[k+1]),
      .borrow     (dec_c[k+1])
    );
  end

  // carry/borrow out of the top digit means the whole value rolled over
  assign ovf = inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS];

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      digits_q <= '0;
      o_Wrap   <= 1'b0;
    end else if (i_Clear) begin
      digits_q <= '0;
      o_Wrap   <= 1'b0;
    end else if (ovf && !WRAP_EN) begin
      digits_q <= digits_q;
      o_Wrap   <= 1'b0;
    end else begin
      digits_q <= digits_nx;
      o_Wrap   <= ovf;
    end
  end

  assign o_Digits = digits_q;

  always_comb begin
    o_At_Max = 1'b1;
    o_At_Min = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digits_q[k] != DIGIT_MAX) o_At_Max = 1'b0;
      if (digits_q[k] != '0)        o_At_Min = 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench: dut A (2 digits, wrap) via vector table + scoreboard,
// dut B (2 digits, saturate) and dut C (4 digits) via hand sequences.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_up, a_dn, a_clr, a_w, a_max, a_min;
  logic [7:0]  a_d;
  logic        b_up, b_dn, b_clr, b_w, b_max, b_min;
  logic [7:0]  b_d;
  logic        c_up, c_dn, c_clr, c_w, c_max, c_min;
  logic [15:0] c_d;

  bcd_updown_counter #(.NUM_DIGITS(2), .WRAP_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_a (
    .i_Clk(clk), .i_Reset(rst), .i_Up(a_up), .i_Down(a_dn), .i_Clear(a_clr),
    .o_Digits(a_d), .o_Wrap(a_w), .o_At_Max(a_max), .o_At_Min(a_min));

  bcd_updown_counter #(.NUM_DIGITS(2), .WRAP_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_b (
    .i_Clk(clk), .i_Reset(rst), .i_Up(b_up), .i_Down(b_dn), .i_Clear(b_clr),
    .o_Digits(b_d), .o_Wrap(b_w), .o_At_Max(b_max), .o_At_Min(b_min));

  bcd_updown_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_c (
    .i_Clk(clk), .i_Reset(rst), .i_Up(c_up), .i_Down(c_dn), .i_Clear(c_clr),
    .o_Digits(c_d), .o_Wrap(c_w), .o_At_Max(c_max), .o_At_Min(c_min));

  int total = 0;
  int bad   = 0;

  typedef struct { logic up; logic dn; logic clr; int v; logic w; } vec_t;
  typedef struct { logic [7:0] d; logic w; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard consumer: compares dut A one time unit after each edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_digits", 32'(a_d), 32'(e.d));
      chk("a_wrap",   32'(a_w), 32'(e.w));
      chk("a_at_max", 32'(a_max), 32'(e.d == 8'h99));
      chk("a_at_min", 32'(a_min), 32'(e.d == 8'h00));
    end
  end

  task automatic drive(input logic up, input logic dn, input logic clr, input int v, input logic w);
    exp_t e;
    a_up = up; a_dn = dn; a_clr = clr;
    e.d = bcd2(v);
    e.w = w;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic up, input logic dn, input logic clr, input int v, input logic w);
    vec_t t;
    t.up = up; t.dn = dn; t.clr = clr; t.v = v; t.w = w;
    tbl.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    rst = 1'b1;
    a_up = 0; a_dn = 0; a_clr = 0;
    b_up = 0; b_dn = 0; b_clr = 0;
    c_up = 0; c_dn = 0; c_clr = 0;
    #12;
    chk("rst_a_digits", 32'(a_d), 32'h0);
    chk("rst_a_wrap",   32'(a_w), 32'h0);
    chk("rst_a_min",    32'(a_min), 32'h1);
    chk("rst_a_max",    32'(a_max), 32'h0);
    chk("rst_b_digits", 32'(b_d), 32'h0);
    chk("rst_c_digits", 32'(c_d), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // ---- vector table for dut A ----
    for (int i = 1; i <= 9; i++) begin add(1,0,0,i,0); add(0,0,0,i,0); end
    add(1,0,0,10,0); add(0,0,0,10,0);                    // 09 -> 10, no wrap
    for (int i = 11; i <= 42; i++) begin add(1,0,0,i,0); add(0,0,0,i,0); end
    add(1,1,0,42,0); add(0,0,0,42,0);                    // opposing edges cancel
    add(1,0,1,0,0);  add(0,0,0,0,0);                     // clear beats up edge
    v = 0;                                               // down held 20 cycles
    for (int t = 0; t < 20; t++) begin
      if (t == 0 || t == 8 || t == 11 || t == 14 || t == 17) v = (v + 99) % 100;
      add(0,1,0,v,(t == 0));
    end
    add(0,0,0,95,0);
    for (int i = 96; i <= 99; i++) begin add(1,0,0,i,0); add(0,0,0,i,0); end
    add(1,0,0,0,1); add(0,0,0,0,0);                      // 99 -> 00 wraps

    foreach (tbl[i]) drive(tbl[i].up, tbl[i].dn, tbl[i].clr, tbl[i].v, tbl[i].w);

    // ---- reset in the middle of an up auto-repeat ----
    drive(0,0,1,0,0);
    for (int i = 1; i <= 37; i++) begin drive(1,0,0,i,0); drive(0,0,0,i,0); end
    drive(1,0,0,38,0);
    for (int t = 1; t <= 7; t++) drive(1,0,0,38,0);
    drive(1,0,0,39,0);
    drive(1,0,0,39,0);
    drive(1,0,0,39,0);
    rst = 1'b1;
    #1;
    chk("rstmid_digits", 32'(a_d), 32'h0);
    chk("rstmid_wrap",   32'(a_w), 32'h0);
    chk("rstmid_min",    32'(a_min), 32'h1);
    #1;
    tick();
    chk("rstmid_hold", 32'(a_d), 32'h0);
    rst = 1'b0;
    drive(1,0,0,1,0);                                    // one step for held level
    drive(1,0,0,1,0);
    drive(1,0,0,1,0);
    drive(0,0,0,1,0);

    // ---- dut B: saturating ends ----
    for (int i = 0; i < 99; i++) begin
      b_up = 1; tick(); b_up = 0; tick();
    end
    chk("b_at99_digits", 32'(b_d), 32'h99);
    chk("b_at99_max",    32'(b_max), 32'h1);
    b_up = 1;
    @(posedge clk); #1;
    chk("b_sat_up_digits", 32'(b_d), 32'h99);
    chk("b_sat_up_wrap",   32'(b_w), 32'h0);
    chk("b_sat_up_max",    32'(b_max), 32'h1);
    #1; b_up = 0;
    @(posedge clk); #1;
    chk("b_sat_up_wrap2", 32'(b_w), 32'h0);
    #1;
    b_clr = 1; tick(); b_clr = 0;
    chk("b_clear", 32'(b_d), 32'h0);
    b_dn = 1;
    @(posedge clk); #1;
    chk("b_sat_dn_digits", 32'(b_d), 32'h0);
    chk("b_sat_dn_wrap",   32'(b_w), 32'h0);
    chk("b_sat_dn_min",    32'(b_min), 32'h1);
    #1; b_dn = 0;
    tick();

    // ---- dut C: 4-digit carry/borrow ripple ----
    for (int i = 0; i < 999; i++) begin
      c_up = 1; tick(); c_up = 0; tick();
    end
    chk("c_0999", 32'(c_d), 32'h0999);
    c_up = 1;
    @(posedge clk); #1;
    chk("c_up_1000",  32'(c_d), 32'h1000);
    chk("c_up_wrap",  32'(c_w), 32'h0);
    #1; c_up = 0; tick();
    c_dn = 1;
    @(posedge clk); #1;
    chk("c_dn_0999",  32'(c_d), 32'h0999);
    chk("c_dn_wrap",  32'(c_w), 32'h0);
    chk("c_dn_min",   32'(c_min), 32'h0);
    #1; c_dn = 0; tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2: BCD digit count, legal 1..8.
REQ-002 Parameter WRAP_EN, default 1: 1 = wrap at the ends; 0 = saturate at the ends.
REQ-003 Parameter REPEAT_DELAY, default 25_000_000: hold cycles before auto-repeat starts (1 s at 25 MHz); 0 disables repeat.
REQ-004 Parameter REPEAT_PERIOD, default 5_000_000: cycles between auto-repeat steps, legal >= 1.
REQ-005 i_Clk  input  1  system clock, all logic on rising edge.
REQ-006 i_Reset  input  1  asynchronous, active-high reset.
REQ-007 i_Up  input  1  debounced level, high = increment request.
REQ-008 i_Down  input  1  debounced level, high = decrement request.
REQ-009 i_Clear  input  1  synchronous clear to zero.
REQ-010 o_Digits  output  4*NUM_DIGITS  BCD value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
REQ-011 o_Wrap  output  1  one-cycle pulse on wrap-around.
REQ-012 o_At_Max  output  1  high when all digits are 9.
REQ-013 o_At_Min  output  1  high when all digits are 0.

Function
REQ-014 The block SHALL register i_Up and i_Down each cycle; a step event occurs on a 0->1 transition of the registered copy versus the current input.
REQ-015 The block SHALL update o_Digits on the same rising edge at which the step event is detected; o_Digits reflects the step one cycle after the input is first sampled high.
REQ-016 Per direction, the block SHALL run a hold counter while the input stays high. On reaching REPEAT_DELAY it SHALL emit a step, then emit one step every REPEAT_PERIOD cycles until the input falls.
REQ-017 The hold counter SHALL clear whenever its input is low.
REQ-018 Each per-direction repeat FSM SHALL have states IDLE, HOLD and REPEAT:
- IDLE->HOLD on an edge.
- HOLD->REPEAT at REPEAT_DELAY.
- any state->IDLE when the input is low.
REQ-019 An increment SHALL add 1 in BCD: a digit at 9 becomes 0 and carries into the next digit; no digit ever holds a value above 9.
REQ-020 A decrement SHALL subtract 1 in BCD: a digit at 0 becomes 9 and borrows from the next digit.
REQ-021 With WRAP_EN=1:
- increment at all-9 SHALL yield all-0 and pulse o_Wrap;
- decrement at all-0 SHALL yield all-9 and pulse o_Wrap.
REQ-022 With WRAP_EN=0: increment at all-9 and decrement at all-0 SHALL leave the value unchanged and SHALL NOT pulse o_Wrap.
REQ-023 Simultaneous up and down steps in the same cycle SHALL cancel: no change, no o_Wrap.
REQ-024 i_Clear SHALL have priority over any step. It SHALL set o_Digits to 0, force both repeat FSMs to IDLE, and keep o_Wrap low.
REQ-025 o_At_Max and o_At_Min SHALL be combinational decodes of the registered o_Digits.
REQ-026 o_Wrap SHALL be registered and high for exactly one cycle per wrap.

Reset
REQ-027 Asserting i_Reset SHALL immediately force:
- o_Digits = 0;
- o_Wrap = 0;
- input history registers = 0;
- hold counters = 0;
- both FSMs = IDLE.
REQ-028 With i_Reset asserted mid-hold, the first step SHALL require a fresh 0->1 edge on i_Up or i_Down after i_Reset deasserts.
REQ-029 Input history registers reset to 0; an input already high at reset release SHALL produce one step.

Structure
REQ-030 FSM state encodings and the BCD constants (digit max 9, digit width 4) SHALL live in the shared project header package.
REQ-031 One sub-module, bcd_digit, SHALL be instantiated NUM_DIGITS times:
- inputs: inc, dec, clear, value;
- outputs: next value, carry, borrow;
- chaining via a generate loop.
REQ-032 Hold counter width SHALL be $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD, plus 1.

Verification (NUM_DIGITS=2, REPEAT_DELAY=8, REPEAT_PERIOD=3 unless noted)
REQ-033 From 09, one i_Up pulse -> o_Digits=0x10, o_Wrap stays 0.
REQ-034 WRAP_EN=1, at 0x99, i_Up edge -> o_Digits=0x00, o_Wrap high for 1 cycle. WRAP_EN=0, same stimulus -> o_Digits stays 0x99, o_At_Max=1, o_Wrap=0.
REQ-035 From 0x00, i_Down held 20 cycles (WRAP_EN=1) -> steps at the initial edge and at hold counts 8, 11, 14, 17 -> o_Digits=0x95.
REQ-036 From 0x42, i_Up and i_Down rise in the same cycle -> o_Digits stays 0x42; i_Clear asserted with i_Up edge -> 0x00.
REQ-037 From 0x37, i_Reset asserted mid-repeat while i_Up held -> o_Digits=0x00 immediately; after release with i_Up still high, exactly one step -> 0x01.
REQ-038 NUM_DIGITS=4, from 0x0999, i_Up edge -> 0x1000; from 0x1000, i_Down edge -> 0x0999.
